// File: rtl/window_5x5_sequencer.sv
// Raster-scan sequencer for a 5x5 sliding-window datapath: tracks row/col,
// issues shift-enables and flags complete windows one cycle after each sample.
module window_5x5_sequencer #(
   parameter int ROWS = 7,
   parameter int COLS = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        done_i,
   input  logic        flush_i,
   output logic        start_o,
   output logic        done_o,
   output logic        frame_done_o,
   output logic [9:0]  row_o,
   output logic [9:0]  col_o,
   output logic [15:0] win_cnt_o,
   output logic        busy_o
);

   localparam logic [9:0] ROW_LAST = 10'(ROWS - 1);
   localparam logic [9:0] COL_LAST = 10'(COLS - 1);

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   state_t     state, state_nxt;
   logic [9:0] row_cnt, col_cnt, row_nxt, col_nxt;
   logic       accept, col_last, row_last, win_hit, frame_last, first_smp;

   assign busy_o = (state != IDLE);

   always_comb begin
      accept     = done_i & ~flush_i;
      col_last   = (col_cnt == COL_LAST);
      row_last   = (row_cnt == ROW_LAST);
      frame_last = accept && row_last && col_last;
      first_smp  = (row_cnt == 10'd0) && (col_cnt == 10'd0);
      win_hit    = accept && (row_cnt >= 10'd4) && (col_cnt >= 10'd4);
      state_nxt  = state;
      row_nxt    = row_cnt;
      col_nxt    = col_cnt;
      if (flush_i) begin
         state_nxt = IDLE;
         row_nxt   = 10'd0;
         col_nxt   = 10'd0;
      end else if (done_i) begin
         // Counters wrap to (0,0) on the last sample so the next frame can
         // start immediately from IDLE.
         if (col_last) begin
            col_nxt = 10'd0;
            row_nxt = row_last ? 10'd0 : row_cnt + 10'd1;
         end else begin
            col_nxt = col_cnt + 10'd1;
         end
         case (state)
            IDLE:    state_nxt = FILL;
            FILL:    if ((row_cnt == 10'd3) && col_last) state_nxt = RUN;
            RUN:     if (row_last && col_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         row_cnt      <= 10'd0;
         col_cnt      <= 10'd0;
         start_o      <= 1'b0;
         done_o       <= 1'b0;
         frame_done_o <= 1'b0;
         row_o        <= 10'd0;
         col_o        <= 10'd0;
         win_cnt_o    <= 16'd0;
      end else begin
         row_cnt      <= row_nxt;
         col_cnt      <= col_nxt;
         start_o      <= accept;
         done_o       <= win_hit;
         frame_done_o <= frame_last;
         if (accept) begin
            row_o <= row_cnt;
            col_o <= col_cnt;
            if (first_smp)
               win_cnt_o <= 16'd0;
            else if (win_hit && (win_cnt_o != 16'hFFFF))
               win_cnt_o <= win_cnt_o + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_window_5x5_sequencer.sv
// Drives a 7x7 and a 5x8 sequencer with identical stimulus and checks both
// against a frame-position model after every clock.
module tb_window_5x5_sequencer;

   logic clk, rst, done_i, flush_i;
   logic [1:0]  start_s, done_s, fd_s, busy_s;
   logic [9:0]  row_s [2];
   logic [9:0]  col_s [2];
   logic [15:0] win_s [2];

   int checks = 0;
   int errors = 0;

   // Model state per instance: samples accepted so far in the current frame.
   int pos [2];
   int e_row [2];
   int e_col [2];
   int e_win [2];
   bit e_st [2];
   bit e_dn [2];
   bit e_fd [2];
   int dcnt [2];

   window_5x5_sequencer u7 (
      .clk(clk), .rst(rst), .done_i(done_i), .flush_i(flush_i),
      .start_o(start_s[0]), .done_o(done_s[0]), .frame_done_o(fd_s[0]),
      .row_o(row_s[0]), .col_o(col_s[0]), .win_cnt_o(win_s[0]), .busy_o(busy_s[0])
   );

   window_5x5_sequencer #(.ROWS(5), .COLS(8)) u58 (
      .clk(clk), .rst(rst), .done_i(done_i), .flush_i(flush_i),
      .start_o(start_s[1]), .done_o(done_s[1]), .frame_done_o(fd_s[1]),
      .row_o(row_s[1]), .col_o(col_s[1]), .win_cnt_o(win_s[1]), .busy_o(busy_s[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input int i, input logic r, input logic d, input logic f);
      int nr, nc;
      nr = (i == 0) ? 7 : 5;
      nc = (i == 0) ? 7 : 8;
      if (!r) begin
         pos[i] = 0; e_row[i] = 0; e_col[i] = 0; e_win[i] = 0;
         e_st[i] = 0; e_dn[i] = 0; e_fd[i] = 0;
      end else if (f) begin
         pos[i] = 0; e_st[i] = 0; e_dn[i] = 0; e_fd[i] = 0;
      end else if (d) begin
         e_row[i] = pos[i] / nc;
         e_col[i] = pos[i] % nc;
         e_st[i]  = 1;
         e_dn[i]  = (e_row[i] >= 4) && (e_col[i] >= 4);
         e_fd[i]  = (pos[i] == nr * nc - 1);
         if (pos[i] == 0) e_win[i] = 0;
         if (e_dn[i] && e_win[i] != 65535) e_win[i]++;
         pos[i] = (pos[i] + 1) % (nr * nc);
      end else begin
         e_st[i] = 0; e_dn[i] = 0; e_fd[i] = 0;
      end
   endtask

   task automatic step(input logic r, input logic d, input logic f);
      @(negedge clk);
      rst = r; done_i = d; flush_i = f;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         model(i, r, d, f);
         chk($sformatf("start%0d", i), 16'(start_s[i]), 16'(e_st[i]));
         chk($sformatf("done%0d", i),  16'(done_s[i]),  16'(e_dn[i]));
         chk($sformatf("fdone%0d", i), 16'(fd_s[i]),    16'(e_fd[i]));
         chk($sformatf("row%0d", i),   16'(row_s[i]),   16'(e_row[i]));
         chk($sformatf("col%0d", i),   16'(col_s[i]),   16'(e_col[i]));
         chk($sformatf("win%0d", i),   win_s[i],        16'(e_win[i]));
         chk($sformatf("busy%0d", i),  16'(busy_s[i]),  16'(pos[i] != 0));
         if (done_s[i] === 1'b1) dcnt[i]++;
      end
   endtask

   task automatic run_samples(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      int first, d0;
      rst = 1'b0; done_i = 1'b0; flush_i = 1'b0;
      dcnt[0] = 0; dcnt[1] = 0;

      // Reset, with done/flush asserted to confirm reset priority.
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0);

      // Continuous 7x7 frame.
      d0 = dcnt[0]; first = 0;
      for (int n = 1; n <= 49; n++) begin
         step(1'b1, 1'b1, 1'b0);
         if (first == 0 && done_s[0] === 1'b1) first = n;
      end
      chk("first_win7", 16'(first), 16'd33);
      chk("frame7_wins", 16'(dcnt[0] - d0), 16'd9);
      chk("frame7_fd", 16'(fd_s[0]), 16'd1);
      step(1'b1, 1'b0, 1'b0);
      chk("idle7_busy", 16'(busy_s[0]), 16'd0);

      // Non-square 5x8 frame.
      step(1'b0, 1'b0, 1'b0);
      d0 = dcnt[1];
      run_samples(40);
      chk("frame58_wins", 16'(dcnt[1] - d0), 16'd4);
      chk("frame58_cnt", win_s[1], 16'd4);

      // Gapped 7x7 frame; counters must hold through idle cycles.
      step(1'b0, 1'b0, 1'b0);
      d0 = dcnt[0];
      for (int n = 0; n < 49; n++) begin
         step(1'b1, 1'b1, 1'b0);
         step(1'b1, 1'b0, 1'b0);
      end
      chk("gapped7_wins", 16'(dcnt[0] - d0), 16'd9);

      // Back-to-back 7x7 frames.
      d0 = dcnt[0];
      run_samples(98);
      chk("b2b7_wins", 16'(dcnt[0] - d0), 16'd18);
      chk("b2b7_cnt", win_s[0], 16'd9);

      // Flush on the 20th sample, then a full frame.
      run_samples(19);
      step(1'b1, 1'b1, 1'b1);
      chk("flush_busy", 16'(busy_s[0]), 16'd0);
      chk("flush_start", 16'(start_s[0]), 16'd0);
      step(1'b1, 1'b0, 1'b1);
      d0 = dcnt[0];
      run_samples(49);
      chk("flush7_wins", 16'(dcnt[0] - d0), 16'd9);

      // Reset during RUN, then a full frame.
      run_samples(30);
      step(1'b0, 1'b1, 1'b0);
      d0 = dcnt[0];
      run_samples(49);
      chk("rst7_wins", 16'(dcnt[0] - d0), 16'd9);

      // Random mix of samples, gaps, flushes and occasional resets.
      for (int n = 0; n < 3000; n++) begin
         logic r, d, f;
         r = ($urandom_range(0, 299) != 0);
         d = ($urandom_range(0, 9) < 7);
         f = ($urandom_range(0, 99) < 2);
         step(r, d, f);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
